pmem_arbiter: RTL and testbench

//  Parametrised N-client arbiter between cache-level line requesters (I-cache, D-cache, L2, prefetch)
//  and the single physical-memory line port. Round-robin grant, one transaction in flight,

---
 rtl/pmem_arbiter_if.sv | 44 ++++
 rtl/pmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_pmem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_if.sv
`timescale 1ns/1ps
// pmem_arbiter_if: client request/response bundle and physical-memory line port
// shared between the arbiter and its clients/memory.
interface pmem_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 128
);
  localparam int IDW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  // client side
  logic [NUM_CLIENTS-1:0]            cl_read;
  logic [NUM_CLIENTS-1:0]            cl_write;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr;
  logic [NUM_CLIENTS*LINE_WIDTH-1:0] cl_wdata;
  logic [NUM_CLIENTS-1:0]            cl_resp;
  logic [LINE_WIDTH-1:0]             cl_rdata;

  // physical memory side
  logic                              pmem_read;
  logic                              pmem_write;
  logic [ADDR_WIDTH-1:0]             pmem_address;
  logic [LINE_WIDTH-1:0]             pmem_wdata;
  logic                              pmem_resp;
  logic [LINE_WIDTH-1:0]             pmem_rdata;

  // status
  logic [IDW-1:0]                    grant_id;
  logic                              proto_err;

  // arbiter view
  modport master (
    input  cl_read, cl_write, cl_addr, cl_wdata, pmem_resp, pmem_rdata,
    output cl_resp, cl_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
    output grant_id, proto_err
  );

  // clients + memory view
  modport slave (
    output cl_read, cl_write, cl_addr, cl_wdata, pmem_resp, pmem_rdata,
    input  cl_resp, cl_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  grant_id, proto_err
  );
endinterface

// File: rtl/pmem_arbiter.sv
`timescale 1ns/1ps
// pmem_arbiter: round-robin N-client arbiter onto a single physical-memory line
// port. One transaction in flight; all outputs registered.
module pmem_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  pmem_arbiter_if.master bus
);
  localparam int IDW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [IDW:0]   NC_W    = (IDW+1)'(NUM_CLIENTS);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_CLIENTS-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state,        w_next_state;
  logic [IDW-1:0]         r_rr_ptr,       w_rr_ptr;
  logic [IDW-1:0]         r_grant_id,     w_grant_id;
  logic [NUM_CLIENTS-1:0] r_cl_resp,      w_cl_resp;
  logic [LINE_WIDTH-1:0]  r_cl_rdata,     w_cl_rdata;
  logic                   r_pmem_read,    w_pmem_read;
  logic                   r_pmem_write,   w_pmem_write;
  logic [ADDR_WIDTH-1:0]  r_pmem_address, w_pmem_address;
  logic [LINE_WIDTH-1:0]  r_pmem_wdata,   w_pmem_wdata;
  logic                   r_proto_err,    w_proto_err;

  logic [NUM_CLIENTS-1:0] w_req;
  logic [IDW:0]           w_idx;
  logic                   w_found;
  logic [IDW-1:0]         w_pick;
  logic [NUM_CLIENTS-1:0] w_onehot;
  logic [IDW-1:0]         w_rr_after;

  // Round-robin search: first requester at rr_ptr, rr_ptr+1, ... modulo NUM_CLIENTS.
  always_comb begin
    w_req   = bus.cl_read | bus.cl_write;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= NC_W) w_idx = w_idx - NC_W;
      if (!w_found && w_req[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IDW-1:0];
      end
    end
  end

  // Completion pulse for the owner and the pointer value that follows it.
  always_comb begin
    w_onehot             = '0;
    w_onehot[r_grant_id] = 1'b1;
    w_rr_after           = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
  end

  // Next-state and next-output logic; every output holds unless changed below.
  always_comb begin
    w_next_state   = r_state;
    w_rr_ptr       = r_rr_ptr;
    w_grant_id     = r_grant_id;
    w_cl_resp      = '0;
    w_cl_rdata     = r_cl_rdata;
    w_pmem_read    = r_pmem_read;
    w_pmem_write   = r_pmem_write;
    w_pmem_address = r_pmem_address;
    w_pmem_wdata   = r_pmem_wdata;
    w_proto_err    = r_proto_err | (bus.pmem_resp && (r_state != S_BUSY));

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_id     = w_pick;
          w_pmem_address = bus.cl_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
          w_pmem_wdata   = bus.cl_wdata[int'(w_pick)*LINE_WIDTH +: LINE_WIDTH];
          // a client asserting both read and write is treated as a write
          w_pmem_write   = bus.cl_write[w_pick];
          w_pmem_read    = ~bus.cl_write[w_pick];
          w_next_state   = S_BUSY;
        end else begin
          w_pmem_read    = 1'b0;
          w_pmem_write   = 1'b0;
        end
      end
      S_BUSY: begin
        if (bus.pmem_resp) begin
          w_pmem_read  = 1'b0;
          w_pmem_write = 1'b0;
          if (!r_pmem_write) w_cl_rdata = bus.pmem_rdata;
          w_cl_resp    = w_onehot;
          w_rr_ptr     = w_rr_after;
          w_next_state = S_RESP;
        end
      end
      // RESP is a one-cycle bubble so a requester that just completed cannot be
      // re-granted on its not-yet-dropped request.
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_pmem_read  = 1'b0;
        w_pmem_write = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_grant_id     <= '0;
      r_cl_resp      <= '0;
      r_cl_rdata     <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_proto_err    <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_rr_ptr       <= w_rr_ptr;
      r_grant_id     <= w_grant_id;
      r_cl_resp      <= w_cl_resp;
      r_cl_rdata     <= w_cl_rdata;
      r_pmem_read    <= w_pmem_read;
      r_pmem_write   <= w_pmem_write;
      r_pmem_address <= w_pmem_address;
      r_pmem_wdata   <= w_pmem_wdata;
      r_proto_err    <= w_proto_err;
    end
  end

  assign bus.cl_resp      = r_cl_resp;
  assign bus.cl_rdata     = r_cl_rdata;
  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_wdata   = r_pmem_wdata;
  assign bus.grant_id     = r_grant_id;
  assign bus.proto_err    = r_proto_err;

endmodule

// File: tb/tb_pmem_arbiter.sv
`timescale 1ns/1ps
// tb_pmem_arbiter: table vectors, directed multi-cycle sequences and a randomized
// run against a transaction-level reference model.
module tb_pmem_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int LW = 128;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   gq[$];
  int   ex[$];

  pmem_arbiter_if #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int              cid;
    logic            rd, wr;
    logic [AW-1:0]   addr;
    logic [LW-1:0]   wdata;
    logic            presp;
    logic [LW-1:0]   prdata;
    logic            e_rd, e_wr;
    logic [AW-1:0]   e_addr;
    logic [LW-1:0]   e_wdata;
    logic [N-1:0]    e_cresp;
    logic [1:0]      e_gid;
    logic [LW-1:0]   e_rdata;
  } vec_t;

  function automatic vec_t mk(input int cid, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [LW-1:0] wd,
                              input logic pr, input logic [LW-1:0] prd,
                              input logic erd, input logic ewr, input logic [AW-1:0] ea,
                              input logic [LW-1:0] ewd, input logic [N-1:0] ecr,
                              input logic [1:0] eg, input logic [LW-1:0] erdat);
    vec_t v;
    v.cid = cid; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
    v.presp = pr; v.prdata = prd;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_wdata = ewd;
    v.e_cresp = ecr; v.e_gid = eg; v.e_rdata = erdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.cl_read    = '0;
    bus.cl_write   = '0;
    bus.cl_addr    = '0;
    bus.cl_wdata   = '0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  task automatic set_client(input int c, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [LW-1:0] d);
    bus.cl_read[c]            = rd;
    bus.cl_write[c]           = wr;
    bus.cl_addr[c*AW +: AW]   = a;
    bus.cl_wdata[c*LW +: LW]  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hold requests from every client in mask; memory answers one cycle after each op.
  task automatic run_fair(input logic [N-1:0] mask, input int n, input string tag);
    do_reset();
    gq.delete();
    for (int c = 0; c < N; c++)
      if (mask[c]) set_client(c, 1'b1, 1'b0, AW'(c * 16), '0);
    for (int cyc = 0; cyc < 200 && gq.size() < n; cyc++) begin
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        gq.push_back(int'(bus.grant_id));
        bus.pmem_resp = 1'b1;
      end
      @(negedge clk);
    end
    clear_inputs();
    chk({tag, " grant count"}, LW'(gq.size()), LW'(n));
    for (int i = 0; i < n && i < gq.size(); i++)
      chk($sformatf("%s grant %0d", tag, i), LW'(gq[i]), LW'(ex[i]));
  endtask

  vec_t tv[17];

  // reference model state (transaction level)
  bit              m_busy, m_cool, m_wr, m_perr;
  int              m_ptr, m_owner;
  logic [AW-1:0]   m_addr;
  logic [LW-1:0]   m_wdata, m_rdata;
  logic [N-1:0]    e_cresp;
  bit              dropnx[N];
  int              mc, d0, d2, c0, c2;
  bit              wsel;

  initial begin
    logic [LW-1:0] A5, O1, DE, C3;
    n_vec = 0;
    n_err = 0;
    A5 = {16{8'hA5}};
    O1 = {8{16'h1111}};
    DE = {4{32'hDEADBEEF}};
    C3 = {16{8'h3C}};

    // single read by client 1, 5-cycle memory
    tv[0]  = mk(1, 1, 0, 16'h1230, '0, 0, '0,  1, 0, 16'h1230, '0, 4'b0000, 1, '0);
    tv[1]  = mk(1, 1, 0, 16'h1230, '0, 0, '0,  1, 0, 16'h1230, '0, 4'b0000, 1, '0);
    tv[2]  = tv[1];
    tv[3]  = tv[1];
    tv[4]  = tv[1];
    tv[5]  = mk(1, 1, 0, 16'h1230, '0, 1, A5,  0, 0, 16'h1230, '0, 4'b0010, 1, A5);
    tv[6]  = mk(1, 1, 0, 16'h1230, '0, 0, '0,  0, 0, 16'h1230, '0, 4'b0000, 1, A5);
    tv[7]  = mk(1, 0, 0, 16'h1230, '0, 0, '0,  0, 0, 16'h1230, '0, 4'b0000, 1, A5);
    // client 0 write; read data must not disturb cl_rdata
    tv[8]  = mk(0, 0, 1, 16'h0040, O1, 0, '0,  0, 1, 16'h0040, O1, 4'b0000, 0, A5);
    tv[9]  = tv[8];
    tv[10] = mk(0, 0, 1, 16'h0040, O1, 1, DE,  0, 0, 16'h0040, O1, 4'b0001, 0, A5);
    tv[11] = mk(0, 0, 0, 16'h0040, O1, 0, '0,  0, 0, 16'h0040, O1, 4'b0000, 0, A5);
    // client 2 read, address changes while busy
    tv[12] = mk(2, 1, 0, 16'h0100, '0, 0, '0,  1, 0, 16'h0100, '0, 4'b0000, 2, A5);
    tv[13] = mk(2, 1, 0, 16'h0200, '0, 0, '0,  1, 0, 16'h0100, '0, 4'b0000, 2, A5);
    tv[14] = tv[13];
    tv[15] = mk(2, 1, 0, 16'h0200, '0, 1, C3,  0, 0, 16'h0100, '0, 4'b0100, 2, C3);
    tv[16] = mk(2, 0, 0, 16'h0200, '0, 0, '0,  0, 0, 16'h0100, '0, 4'b0000, 2, C3);

    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("reset pmem_read",    LW'(bus.pmem_read),    '0);
    chk("reset pmem_write",   LW'(bus.pmem_write),   '0);
    chk("reset pmem_address", LW'(bus.pmem_address), '0);
    chk("reset pmem_wdata",   bus.pmem_wdata,        '0);
    chk("reset cl_resp",      LW'(bus.cl_resp),      '0);
    chk("reset cl_rdata",     bus.cl_rdata,          '0);
    chk("reset grant_id",     LW'(bus.grant_id),     '0);
    chk("reset proto_err",    LW'(bus.proto_err),    '0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    for (int k = 0; k < 17; k++) begin
      clear_inputs();
      set_client(tv[k].cid, tv[k].rd, tv[k].wr, tv[k].addr, tv[k].wdata);
      bus.pmem_resp  = tv[k].presp;
      bus.pmem_rdata = tv[k].prdata;
      @(negedge clk);
      chk($sformatf("t%0d pmem_read", k),    LW'(bus.pmem_read),    LW'(tv[k].e_rd));
      chk($sformatf("t%0d pmem_write", k),   LW'(bus.pmem_write),   LW'(tv[k].e_wr));
      chk($sformatf("t%0d pmem_address", k), LW'(bus.pmem_address), LW'(tv[k].e_addr));
      chk($sformatf("t%0d pmem_wdata", k),   bus.pmem_wdata,        tv[k].e_wdata);
      chk($sformatf("t%0d cl_resp", k),      LW'(bus.cl_resp),      LW'(tv[k].e_cresp));
      chk($sformatf("t%0d grant_id", k),     LW'(bus.grant_id),     LW'(tv[k].e_gid));
      chk($sformatf("t%0d cl_rdata", k),     bus.cl_rdata,          tv[k].e_rdata);
      chk($sformatf("t%0d proto_err", k),    LW'(bus.proto_err),    '0);
    end
    clear_inputs();

    // fairness
    ex = '{0, 1, 0, 1};
    run_fair(4'b0011, 4, "fair2");
    ex = '{0, 1, 2, 3, 0};
    run_fair(4'b1111, 5, "fair4");

    // reset in the middle of a read, then a stray memory response
    do_reset();
    set_client(0, 1'b1, 1'b0, 16'h0ABC, '0);
    @(negedge clk);
    chk("mid-reset op started", LW'(bus.pmem_read), LW'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-reset pmem_read async drop", LW'(bus.pmem_read), '0);
    chk("mid-reset cl_resp",              LW'(bus.cl_resp),   '0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    chk("post-reset proto_err clear", LW'(bus.proto_err), '0);
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    chk("stray resp proto_err", LW'(bus.proto_err), LW'(1));
    chk("stray resp cl_resp",   LW'(bus.cl_resp),   '0);
    chk("stray resp pmem_read", LW'(bus.pmem_read), '0);
    @(negedge clk);
    chk("proto_err sticky", LW'(bus.proto_err), LW'(1));

    // stale request held one cycle past cl_resp while client 2 waits
    do_reset();
    gq.delete();
    d0 = 0; d2 = 0; c0 = 0; c2 = 0;
    set_client(0, 1'b1, 1'b0, 16'h0010, '0);
    set_client(2, 1'b1, 1'b0, 16'h0030, '0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (d0 > 0) begin d0--; if (d0 == 0) set_client(0, 1'b0, 1'b0, 16'h0010, '0); end
      if (d2 > 0) begin d2--; if (d2 == 0) set_client(2, 1'b0, 1'b0, 16'h0030, '0); end
      if (bus.cl_resp[0]) begin c0++; d0 = 2; end
      if (bus.cl_resp[2]) begin c2++; d2 = 1; end
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        gq.push_back(int'(bus.grant_id));
        bus.pmem_resp = 1'b1;
      end
      @(negedge clk);
    end
    clear_inputs();
    chk("stale grant count",  LW'(gq.size()), LW'(2));
    chk("stale first grant",  LW'(gq.size() > 0 ? gq[0] : -1), LW'(0));
    chk("stale second grant", LW'(gq.size() > 1 ? gq[1] : -1), LW'(2));
    chk("stale c0 pulses",    LW'(c0), LW'(1));
    chk("stale c2 pulses",    LW'(c2), LW'(1));

    // randomized run against the reference model
    do_reset();
    m_busy = 0; m_cool = 0; m_wr = 0; m_perr = 0;
    m_ptr = 0; m_owner = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    mc = -1;
    for (int c = 0; c < N; c++) dropnx[c] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      // clients
      for (int c = 0; c < N; c++) begin
        if (dropnx[c]) begin
          bus.cl_read[c] = 1'b0; bus.cl_write[c] = 1'b0; dropnx[c] = 0;
        end else if (bus.cl_resp[c]) begin
          dropnx[c] = 1;
        end else if (!(bus.cl_read[c] || bus.cl_write[c])) begin
          if ($urandom_range(0, 2) == 0) begin
            wsel = 1'($urandom_range(0, 1));
            set_client(c, !wsel, wsel, AW'($urandom),
                       {$urandom, $urandom, $urandom, $urandom});
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_client(c, bus.cl_read[c], bus.cl_write[c], AW'($urandom),
                     {$urandom, $urandom, $urandom, $urandom});
        end
      end
      // memory
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (!(bus.pmem_read || bus.pmem_write)) mc = -1;
      else if (mc == -1) mc = $urandom_range(0, 4);
      if (mc == 0) begin bus.pmem_resp = 1'b1; mc = -2; end
      else if (mc > 0) mc--;

      @(negedge clk);

      // model: the inputs on the bus are what the last rising edge sampled
      e_cresp = '0;
      if (bus.pmem_resp && !m_busy) m_perr = 1;
      if (m_busy) begin
        if (bus.pmem_resp) begin
          m_busy = 0;
          e_cresp[m_owner] = 1'b1;
          if (!m_wr) m_rdata = bus.pmem_rdata;
          m_ptr  = (m_owner + 1) % N;
          m_cool = 1;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else begin
        for (int j = 0; j < N; j++) begin
          int c;
          c = (m_ptr + j) % N;
          if (!m_busy && (bus.cl_read[c] || bus.cl_write[c])) begin
            m_busy  = 1;
            m_owner = c;
            m_wr    = bus.cl_write[c];
            m_addr  = bus.cl_addr[c*AW +: AW];
            m_wdata = bus.cl_wdata[c*LW +: LW];
          end
        end
      end
      chk("rnd pmem_read",    LW'(bus.pmem_read),    LW'(m_busy && !m_wr));
      chk("rnd pmem_write",   LW'(bus.pmem_write),   LW'(m_busy && m_wr));
      chk("rnd pmem_address", LW'(bus.pmem_address), LW'(m_addr));
      chk("rnd pmem_wdata",   bus.pmem_wdata,        m_wdata);
      chk("rnd grant_id",     LW'(bus.grant_id),     LW'(m_owner));
      chk("rnd cl_resp",      LW'(bus.cl_resp),      LW'(e_cresp));
      chk("rnd cl_rdata",     bus.cl_rdata,          m_rdata);
      chk("rnd proto_err",    LW'(bus.proto_err),    LW'(m_perr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
